// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the MEM pipeline stage:
//   state_t      - handshake FSM states (IDLE, REQ, WAIT)
//   SZ_B..SZ_D   - transfer size encodings (log2 of byte count)
//   bytes_of()   - byte count of a transfer size
//   size_mask()  - low address bits that must be zero for an aligned access
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Number of bytes moved by a transfer of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Address bits that must be clear for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [3:0] mask_v;
    mask_v = bytes_of(size) - 4'd1;
    return mask_v[2:0];
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Purely combinational load-data formatter: keeps the low 2^size bytes of the
// right-justified read data and sign- or zero-extends them to DATA_W.
// Ports:
//   rdata       in  DATA_W  raw read data, right-justified
//   size        in  2       log2 of the access byte count
//   load_signed in  1       1 = sign-extend, 0 = zero-extend
//   ext_data    out DATA_W  extended load value
// -----------------------------------------------------------------------------
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              load_signed,
  output logic [DATA_W-1:0] ext_data
);

  // Bit-wise select between loaded bits and the replicated sign bit; sizes
  // wider than the datapath are clamped so the index never leaves rdata.
  always_comb begin
    int   nbits_v;
    int   top_v;
    logic sign_v;
    nbits_v  = 32'sd8 * int'(bytes_of(size));
    top_v    = (nbits_v > DATA_W) ? DATA_W : nbits_v;
    sign_v   = 1'b0;
    ext_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == (top_v - 32'sd1)) begin
        sign_v = load_signed & rdata[i];
      end else begin
        sign_v = sign_v;
      end
    end
    for (int i = 0; i < DATA_W; i++) begin
      ext_data[i] = (i < top_v) ? rdata[i] : sign_v;
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// -----------------------------------------------------------------------------
// mem_stage_hs
// Memory stage between EX and WB. Resolves branches combinationally, issues
// loads/stores over a valid/ready request + response-valid handshake, stalls
// upstream while an access is outstanding, and owns the MEM/WB register.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid / in_ready          EX->MEM handshake (in_ready=1 only in IDLE)
//   alu_result .. reg_write      EX/MEM pipeline fields
//   br_taken, new_pc             branch resolution
//   mem_req_*                    data memory request channel
//   mem_resp_valid/rdata         data memory read response
//   out_*                        MEM/WB register (out_valid pulses one cycle)
// -----------------------------------------------------------------------------
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int REG_AW      = 5,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] add_result,
  input  logic              zero,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [1:0]        xfer_size,
  input  logic              load_signed,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  output logic              br_taken,
  output logic [ADDR_W-1:0] new_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [1:0]        mem_req_size,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_misalign
);

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        size_r;
  logic              we_r;
  logic [REG_AW-1:0] rd_r;
  logic              reg_write_r;
  logic              mem_to_reg_r;
  logic              load_signed_r;

  logic              out_valid_r;
  logic [REG_AW-1:0] out_rd_r;
  logic              out_reg_write_r;
  logic [DATA_W-1:0] out_wb_data_r;
  logic              out_misalign_r;

  logic              accept_s;
  logic              mem_op_s;
  logic              misalign_s;
  logic              too_big_s;
  logic              err_s;
  logic [DATA_W-1:0] ext_s;

  // Request channel is driven straight from the captured fields so it stays
  // stable until the memory accepts; valid drops with an async reset.
  assign in_ready      = (state_r == IDLE);
  assign mem_req_valid = (state_r == REQ);
  assign mem_req_we    = we_r;
  assign mem_req_addr  = addr_r;
  assign mem_req_wdata = wdata_r;
  assign mem_req_size  = size_r;

  assign out_valid     = out_valid_r;
  assign out_rd        = out_rd_r;
  assign out_reg_write = out_reg_write_r;
  assign out_wb_data   = out_wb_data_r;
  assign out_misalign  = out_misalign_r;

  assign accept_s = in_valid & in_ready;
  assign br_taken = accept_s & (uncond_branch | (branch & zero));
  assign new_pc   = add_result;

  // Access legality: misalignment (when checked) or a size wider than the bus.
  always_comb begin
    mem_op_s   = mem_read | mem_write;
    misalign_s = CHECK_ALIGN && ((alu_result[2:0] & size_mask(xfer_size)) != 3'd0);
    too_big_s  = int'(bytes_of(xfer_size)) > (DATA_W / 8);
    err_s      = mem_op_s & (misalign_s | too_big_s);
  end

  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .rdata      (mem_resp_rdata),
    .size       (size_r),
    .load_signed(load_signed_r),
    .ext_data   (ext_s)
  );

  // Handshake FSM plus request capture and the MEM/WB output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      addr_r          <= '0;
      wdata_r         <= '0;
      size_r          <= 2'd0;
      we_r            <= 1'b0;
      rd_r            <= '0;
      reg_write_r     <= 1'b0;
      mem_to_reg_r    <= 1'b0;
      load_signed_r   <= 1'b0;
      out_valid_r     <= 1'b0;
      out_rd_r        <= '0;
      out_reg_write_r <= 1'b0;
      out_wb_data_r   <= '0;
      out_misalign_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && (!mem_op_s || err_s)) begin
            // Non-memory op or rejected access: retire next cycle.
            out_valid_r     <= 1'b1;
            out_rd_r        <= rd;
            out_wb_data_r   <= DATA_W'(alu_result);
            out_reg_write_r <= reg_write & ~err_s;
            out_misalign_r  <= err_s;
          end else if (accept_s) begin
            // A request with both read and write set is treated as a store.
            addr_r        <= alu_result;
            wdata_r       <= write_data;
            size_r        <= xfer_size;
            we_r          <= mem_write;
            rd_r          <= rd;
            reg_write_r   <= reg_write;
            mem_to_reg_r  <= mem_to_reg;
            load_signed_r <= load_signed;
            state_r       <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (mem_req_ready && we_r) begin
            out_valid_r     <= 1'b1;
            out_rd_r        <= rd_r;
            out_wb_data_r   <= DATA_W'(addr_r);
            out_reg_write_r <= 1'b0;
            out_misalign_r  <= 1'b0;
            state_r         <= IDLE;
          end else if (mem_req_ready) begin
            // A response in the accept cycle cannot belong to this load.
            state_r <= WAIT;
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            out_valid_r     <= 1'b1;
            out_rd_r        <= rd_r;
            out_wb_data_r   <= mem_to_reg_r ? ext_s : DATA_W'(addr_r);
            out_reg_write_r <= reg_write_r;
            out_misalign_r  <= 1'b0;
            state_r         <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
